// File: rtl/sdram_scheduler_pkg.sv
// Shared definitions for the SDRAM scheduler and the engines it sequences.
// Holds scheduler state encodings, parameter defaults and SDRAM command codes.
package sdram_scheduler_pkg;

    localparam int unsigned RefPeriodDefault = 780;
    localparam int unsigned MaxDebtDefault   = 8;
    localparam int unsigned TimeoutDefault   = 20000;

    typedef enum logic [5:0] {
        StReset = 6'b00_0001,
        StInit  = 6'b00_0010,
        StIdle  = 6'b00_0100,
        StRef   = 6'b00_1000,
        StWr    = 6'b01_0000,
        StRd    = 6'b10_0000
    } sched_state_e;

    // {cs_n, ras_n, cas_n, we_n} as driven by the engines on the DRAM pins
    typedef enum logic [3:0] {
        CmdLoadMode  = 4'b0000,
        CmdRefresh   = 4'b0001,
        CmdPrecharge = 4'b0010,
        CmdActive    = 4'b0011,
        CmdWrite     = 4'b0100,
        CmdRead      = 4'b0101,
        CmdNop       = 4'b0111
    } sdram_cmd_e;

    function automatic logic is_engine(input sched_state_e s);
        return s inside {StInit, StRef, StWr, StRd};
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Auto-refresh period counter with a saturating count of owed refreshes.
// A demand arriving while the debt is already full sets a sticky overrun flag.
module sdram_refresh_timer #(
    parameter int unsigned REF_PERIOD = 780,
    parameter int unsigned MAX_DEBT   = 8
) (
    input  logic iclk,
    input  logic ireset,
    input  logic ienable,
    input  logic idec,
    output logic odebt_nz,
    output logic ooverrun
);

    localparam int unsigned CntW  = $clog2(REF_PERIOD);
    localparam int unsigned DebtW = $clog2(MAX_DEBT + 1);
    localparam logic [CntW-1:0]  CntLast = CntW'(REF_PERIOD - 1);
    localparam logic [DebtW-1:0] DebtMax = DebtW'(MAX_DEBT);

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [DebtW-1:0] debt_q, debt_d;
    logic             overrun_q, overrun_d;
    logic             wrap, dec;

    always_comb begin
        wrap      = ienable && (cnt_q == CntLast);
        dec       = idec && (debt_q != '0);
        cnt_d     = cnt_q;
        debt_d    = debt_q;
        overrun_d = overrun_q;
        if (ienable) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
        // A wrap coinciding with a completed refresh leaves the debt unchanged
        if (wrap && !dec) begin
            if (debt_q < DebtMax) begin
                debt_d = debt_q + 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (dec && !wrap) begin
            debt_d = debt_q - 1'b1;
        end
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            cnt_q     <= '0;
            debt_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            debt_q    <= debt_d;
            overrun_q <= overrun_d;
        end
    end

    assign odebt_nz = (debt_q != '0);
    assign ooverrun = overrun_q;

endmodule

// File: rtl/sdram_scheduler.sv
// Grants the DRAM pins to one engine at a time: init once, then refresh debt first,
// then write/read requesters round-robin, with a watchdog aborting stuck grants.
import sdram_scheduler_pkg::*;

module sdram_scheduler #(
    parameter int unsigned REF_PERIOD = RefPeriodDefault,
    parameter int unsigned MAX_DEBT   = MaxDebtDefault,
    parameter int unsigned TIMEOUT    = TimeoutDefault
) (
    input  logic iclk,
    input  logic ireset,
    input  logic iwr_req,
    input  logic ird_req,
    output logic owr_ack,
    output logic ord_ack,
    output logic oready,
    output logic oinit_req,
    output logic oinit_enb,
    output logic oref_req,
    output logic oref_enb,
    output logic owr_req,
    output logic owr_enb,
    output logic ord_req,
    output logic ord_enb,
    input  logic iinit_fin,
    input  logic iref_fin,
    input  logic iwr_fin,
    input  logic ird_fin,
    output logic oref_overrun,
    output logic oerr
);

    localparam int unsigned WdW = $clog2(TIMEOUT + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

    sched_state_e   state_q, state_d;
    logic           first_q;
    logic           ready_q;
    logic           wr_ack_q, rd_ack_q;
    logic           last_wr_q;
    logic           err_q;
    logic [WdW-1:0] wd_q;

    logic in_engine, timeout, fin_cur, abort;
    logic wr_pend, rd_pend, debt_nz;
    logic init_done, ref_done, wr_done, rd_done;

    always_comb begin
        in_engine = is_engine(state_q);
        timeout   = in_engine && (wd_q == WdLast);
        init_done = (state_q == StInit) && iinit_fin;
        ref_done  = (state_q == StRef) && iref_fin;
        wr_done   = (state_q == StWr) && iwr_fin;
        rd_done   = (state_q == StRd) && ird_fin;
        fin_cur   = init_done || ref_done || wr_done || rd_done;
        abort     = timeout && !fin_cur;
        // A requester being acked this cycle is still holding its level request
        wr_pend   = iwr_req && !wr_ack_q;
        rd_pend   = ird_req && !rd_ack_q;

        state_d = state_q;
        unique case (state_q)
            StReset: state_d = StInit;
            StInit: begin
                if (init_done) state_d = StIdle;
                else if (abort) state_d = StReset;
            end
            StIdle: begin
                if (debt_nz) state_d = StRef;
                else if (wr_pend && rd_pend) state_d = last_wr_q ? StRd : StWr;
                else if (wr_pend) state_d = StWr;
                else if (rd_pend) state_d = StRd;
            end
            StRef: if (ref_done || abort) state_d = StIdle;
            StWr:  if (wr_done || abort) state_d = StIdle;
            StRd:  if (rd_done || abort) state_d = StIdle;
            default: state_d = StReset;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state_q   <= StReset;
            first_q   <= 1'b0;
            ready_q   <= 1'b0;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            last_wr_q <= 1'b1;
            err_q     <= 1'b0;
            wd_q      <= '0;
        end else begin
            state_q  <= state_d;
            first_q  <= (state_d != state_q);
            wr_ack_q <= wr_done;
            rd_ack_q <= rd_done;
            if (init_done) ready_q <= 1'b1;
            if (wr_done) last_wr_q <= 1'b1;
            else if (rd_done) last_wr_q <= 1'b0;
            if (abort) err_q <= 1'b1;
            if ((state_d != state_q) || !in_engine) wd_q <= '0;
            else wd_q <= wd_q + 1'b1;
        end
    end

    sdram_refresh_timer #(
        .REF_PERIOD(REF_PERIOD),
        .MAX_DEBT  (MAX_DEBT)
    ) u_refresh_timer (
        .iclk    (iclk),
        .ireset  (ireset),
        .ienable (ready_q),
        .idec    (ref_done),
        .odebt_nz(debt_nz),
        .ooverrun(oref_overrun)
    );

    assign oinit_enb = (state_q == StInit);
    assign oref_enb  = (state_q == StRef);
    assign owr_enb   = (state_q == StWr);
    assign ord_enb   = (state_q == StRd);
    assign oinit_req = oinit_enb && first_q;
    assign oref_req  = oref_enb && first_q;
    assign owr_req   = owr_enb && first_q;
    assign ord_req   = ord_enb && first_q;
    assign owr_ack   = wr_ack_q;
    assign ord_ack   = rd_ack_q;
    assign oready    = ready_q;
    assign oerr      = err_q;

endmodule

// File: tb/tb_sdram_scheduler.sv
// Directed bench for sdram_scheduler: three instances with default, fast-refresh and
// tiny-timeout parameters, each scenario a task with hand-computed expectations.
module tb_sdram_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst[3], wr_req[3], rd_req[3], init_fin[3], ref_fin[3], wr_fin[3], rd_fin[3];
    logic wr_ack[3], rd_ack[3], ready[3], overrun[3], err[3];
    logic eng_init_req[3], eng_init_enb[3], eng_ref_req[3], eng_ref_enb[3];
    logic eng_wr_req[3], eng_wr_enb[3], eng_rd_req[3], eng_rd_enb[3];

    int checks = 0;
    int errors = 0;

    // Bit positions of the packed output snapshot
    localparam logic [12:0] OReady   = 13'h1000;
    localparam logic [12:0] OInitReq = 13'h0800;
    localparam logic [12:0] OInitEnb = 13'h0400;
    localparam logic [12:0] ORefReq  = 13'h0200;
    localparam logic [12:0] ORefEnb  = 13'h0100;
    localparam logic [12:0] OWrReq   = 13'h0080;
    localparam logic [12:0] OWrEnb   = 13'h0040;
    localparam logic [12:0] ORdReq   = 13'h0020;
    localparam logic [12:0] ORdEnb   = 13'h0010;
    localparam logic [12:0] OWrAck   = 13'h0008;
    localparam logic [12:0] ORdAck   = 13'h0004;
    localparam logic [12:0] OOverrun = 13'h0002;
    localparam logic [12:0] OErr     = 13'h0001;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sdram_scheduler #(
            .REF_PERIOD(g == 0 ? 780 : (g == 1 ? 16 : 4)),
            .MAX_DEBT  (g == 2 ? 2 : 8),
            .TIMEOUT   (g == 2 ? 50 : 20000)
        ) u_dut (
            .iclk        (clk),
            .ireset      (rst[g]),
            .iwr_req     (wr_req[g]),
            .ird_req     (rd_req[g]),
            .owr_ack     (wr_ack[g]),
            .ord_ack     (rd_ack[g]),
            .oready      (ready[g]),
            .oinit_req   (eng_init_req[g]),
            .oinit_enb   (eng_init_enb[g]),
            .oref_req    (eng_ref_req[g]),
            .oref_enb    (eng_ref_enb[g]),
            .owr_req     (eng_wr_req[g]),
            .owr_enb     (eng_wr_enb[g]),
            .ord_req     (eng_rd_req[g]),
            .ord_enb     (eng_rd_enb[g]),
            .iinit_fin   (init_fin[g]),
            .iref_fin    (ref_fin[g]),
            .iwr_fin     (wr_fin[g]),
            .ird_fin     (rd_fin[g]),
            .oref_overrun(overrun[g]),
            .oerr        (err[g])
        );
    end

    function automatic logic [12:0] outs(input int d);
        return {ready[d], eng_init_req[d], eng_init_enb[d], eng_ref_req[d], eng_ref_enb[d],
                eng_wr_req[d], eng_wr_enb[d], eng_rd_req[d], eng_rd_enb[d],
                wr_ack[d], rd_ack[d], overrun[d], err[d]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst[0] = 1'b1;
        tick();
        tick();
        checks++;
        if (outs(0) !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want %b", outs(0), 13'h0);
        end
    endtask

    task automatic test_init();
        int n = 1;
        int stray = 0;
        rst[0] = 1'b0;
        tick();
        checks++;
        if (outs(0) !== (OInitReq | OInitEnb)) begin
            errors++;
            $display("FAIL init_first: got %b want %b", outs(0), OInitReq | OInitEnb);
        end
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (eng_init_enb[0] === 1'b1) n++;
            if (eng_init_req[0] !== 1'b0) stray++;
            if (k == 10) init_fin[0] = 1'b1;
        end
        tick();
        checks++;
        if (n != 11 || stray != 0) begin
            errors++;
            $display("FAIL init_enb_len: got %0d cycles (%0d req) want 11 (0 req)", n, stray);
        end
        checks++;
        if (outs(0) !== OReady) begin
            errors++;
            $display("FAIL init_ready: got %b want %b", outs(0), OReady);
        end
        stray = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (eng_init_enb[0] !== 1'b0 || ready[0] !== 1'b1) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL init_no_regrant: got %0d bad cycles want 0", stray);
        end
    endtask

    task automatic test_single_write();
        int n = 1;
        wr_req[0] = 1'b1;
        tick();
        checks++;
        if (outs(0) !== (OReady | OWrReq | OWrEnb)) begin
            errors++;
            $display("FAIL wr_grant: got %b want %b", outs(0), OReady | OWrReq | OWrEnb);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (eng_wr_enb[0] === 1'b1 && eng_wr_req[0] === 1'b0) n++;
            if (k == 5) wr_fin[0] = 1'b1;
        end
        tick();
        checks++;
        if (outs(0) !== (OReady | OWrAck)) begin
            errors++;
            $display("FAIL wr_ack: got %b want %b", outs(0), OReady | OWrAck);
        end
        wr_req[0] = 1'b0;
        wr_fin[0] = 1'b0;
        tick();
        checks++;
        if (outs(0) !== OReady || n != 6) begin
            errors++;
            $display("FAIL wr_idle: got %b len %0d want %b len 6", outs(0), n, OReady);
        end
    endtask

    task automatic test_back_to_back();
        logic       is_rd;
        logic       got;
        logic [12:0] want;
        wr_req[0] = 1'b1;
        rd_req[0] = 1'b1;
        for (int g = 0; g < 4; g++) begin
            is_rd = (g % 2 == 0);
            got = 1'b0;
            for (int w = 0; w < 6 && !got; w++) begin
                tick();
                got = eng_wr_enb[0] || eng_rd_enb[0];
            end
            want = is_rd ? (OReady | ORdReq | ORdEnb) : (OReady | OWrReq | OWrEnb);
            checks++;
            if (outs(0) !== want) begin
                errors++;
                $display("FAIL rr_grant%0d: got %b want %b", g, outs(0), want);
            end
            if (is_rd) rd_fin[0] = 1'b1;
            else wr_fin[0] = 1'b1;
            tick();
            rd_fin[0] = 1'b0;
            wr_fin[0] = 1'b0;
            if (g == 3) begin
                wr_req[0] = 1'b0;
                rd_req[0] = 1'b0;
            end
            want = is_rd ? (OReady | ORdAck) : (OReady | OWrAck);
            checks++;
            if (outs(0) !== want) begin
                errors++;
                $display("FAIL rr_ack%0d: got %b want %b", g, outs(0), want);
            end
        end
        tick();
        checks++;
        if (outs(0) !== OReady) begin
            errors++;
            $display("FAIL rr_idle: got %b want %b", outs(0), OReady);
        end
    endtask

    task automatic test_refresh_debt();
        int n = 1;
        logic got;
        logic [12:0] want;
        init_fin[1] = 1'b1;
        rst[1] = 1'b0;
        tick();
        tick();
        wr_req[1] = 1'b1;
        tick();
        checks++;
        if (outs(1) !== (OReady | OWrReq | OWrEnb)) begin
            errors++;
            $display("FAIL debt_wr_grant: got %b want %b", outs(1), OReady | OWrReq | OWrEnb);
        end
        for (int k = 2; k <= 40; k++) begin
            tick();
            if (eng_wr_enb[1] === 1'b1) n++;
            if (k == 40) wr_fin[1] = 1'b1;
        end
        tick();
        checks++;
        if (outs(1) !== (OReady | OWrAck) || n != 40) begin
            errors++;
            $display("FAIL debt_wr_done: got %b len %0d want %b len 40",
                     outs(1), n, OReady | OWrAck);
        end
        wr_req[1] = 1'b0;
        wr_fin[1] = 1'b0;
        rd_req[1] = 1'b1;
        for (int g = 0; g < 3; g++) begin
            got = 1'b0;
            for (int w = 0; w < 6 && !got; w++) begin
                tick();
                got = eng_ref_enb[1] || eng_rd_enb[1];
            end
            want = (g < 2) ? (OReady | ORefReq | ORefEnb) : (OReady | ORdReq | ORdEnb);
            checks++;
            if (outs(1) !== want) begin
                errors++;
                $display("FAIL debt_grant%0d: got %b want %b", g, outs(1), want);
            end
            if (g < 2) ref_fin[1] = 1'b1;
            else rd_fin[1] = 1'b1;
            tick();
            ref_fin[1] = 1'b0;
            rd_fin[1] = 1'b0;
            if (g == 2) rd_req[1] = 1'b0;
        end
    endtask

    task automatic test_reset_mid_write();
        logic got = 1'b0;
        wr_req[1] = 1'b1;
        for (int w = 0; w < 20 && !got; w++) begin
            tick();
            ref_fin[1] = eng_ref_enb[1];
            got = eng_wr_enb[1];
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL midwr_grant: got no write grant within 20 cycles want grant");
        end
        ref_fin[1] = 1'b0;
        tick();
        tick();
        rst[1] = 1'b1;
        tick();
        checks++;
        if (outs(1) !== 13'h0) begin
            errors++;
            $display("FAIL midwr_reset: got %b want %b", outs(1), 13'h0);
        end
        rst[1] = 1'b0;
        wr_req[1] = 1'b0;
        tick();
        checks++;
        if (outs(1) !== (OInitReq | OInitEnb)) begin
            errors++;
            $display("FAIL midwr_reinit: got %b want %b", outs(1), OInitReq | OInitEnb);
        end
    endtask

    task automatic test_overrun_timeout();
        int w = 0;
        init_fin[2] = 1'b1;
        rst[2] = 1'b0;
        tick();
        tick();
        while (w < 10 && eng_ref_enb[2] !== 1'b1) begin
            tick();
            w++;
        end
        checks++;
        if (w != 5 || outs(2) !== (OReady | ORefReq | ORefEnb)) begin
            errors++;
            $display("FAIL ovr_first_ref: got %b after %0d cycles want %b after 5",
                     outs(2), w, OReady | ORefReq | ORefEnb);
        end
        repeat (15) tick();
        checks++;
        if (outs(2) !== (OReady | ORefEnb | OOverrun)) begin
            errors++;
            $display("FAIL ovr_sticky: got %b want %b", outs(2), OReady | ORefEnb | OOverrun);
        end
        repeat (34) tick();
        checks++;
        if (outs(2) !== (OReady | ORefEnb | OOverrun)) begin
            errors++;
            $display("FAIL ovr_last_cycle: got %b want %b", outs(2), OReady | ORefEnb | OOverrun);
        end
        tick();
        checks++;
        if (outs(2) !== (OReady | OOverrun | OErr)) begin
            errors++;
            $display("FAIL ovr_abort: got %b want %b", outs(2), OReady | OOverrun | OErr);
        end
        tick();
        checks++;
        if (outs(2) !== (OReady | ORefReq | ORefEnb | OOverrun | OErr)) begin
            errors++;
            $display("FAIL ovr_regrant: got %b want %b", outs(2),
                     OReady | ORefReq | ORefEnb | OOverrun | OErr);
        end
    endtask

    task automatic test_init_timeout();
        int n = 1;
        rst[2] = 1'b1;
        init_fin[2] = 1'b0;
        tick();
        checks++;
        if (outs(2) !== 13'h0) begin
            errors++;
            $display("FAIL sticky_clear: got %b want %b", outs(2), 13'h0);
        end
        rst[2] = 1'b0;
        tick();
        for (int k = 1; k <= 49; k++) begin
            tick();
            if (eng_init_enb[2] === 1'b1 && err[2] === 1'b0) n++;
        end
        tick();
        checks++;
        if (outs(2) !== OErr || n != 50) begin
            errors++;
            $display("FAIL init_abort: got %b len %0d want %b len 50", outs(2), n, OErr);
        end
        tick();
        checks++;
        if (outs(2) !== (OInitReq | OInitEnb | OErr)) begin
            errors++;
            $display("FAIL init_retry: got %b want %b", outs(2), OInitReq | OInitEnb | OErr);
        end
        init_fin[2] = 1'b1;
        tick();
        checks++;
        if (outs(2) !== (OReady | OErr)) begin
            errors++;
            $display("FAIL init_retry_done: got %b want %b", outs(2), OReady | OErr);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1;
            wr_req[d] = 1'b0;
            rd_req[d] = 1'b0;
            init_fin[d] = 1'b0;
            ref_fin[d] = 1'b0;
            wr_fin[d] = 1'b0;
            rd_fin[d] = 1'b0;
        end
        test_reset();
        test_init();
        test_single_write();
        test_back_to_back();
        test_refresh_debt();
        test_reset_mid_write();
        test_overrun_timeout();
        test_init_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running at 200000 time units");
        $fatal(1);
    end

endmodule
